// File: rtl/cpu_exec_unit.sv
// 4-bit accumulator execution unit: multi-cycle FETCH/DECODE/EXECUTE/ADVANCE
// sequencer with a sticky HALT, four general registers and a display register.
module cpu_exec_unit #(
  parameter logic [3:0] REG_INIT = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instruction,
  input  logic       run_en,
  output logic       pc_enable,
  output logic [3:0] acc,
  output logic [3:0] out_reg,
  output logic       carry,
  output logic       zero,
  output logic       halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    ADVANCE = 3'd3,
    HALT    = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LDI  = 4'h1, OP_ADDI = 4'h2, OP_SUBI = 4'h3,
    OP_ANDI = 4'h4, OP_ORI  = 4'h5, OP_XORI = 4'h6, OP_STR  = 4'h7,
    OP_LDR  = 4'h8, OP_ADDR = 4'h9, OP_SHL  = 4'hA, OP_SHR  = 4'hB,
    OP_OUT  = 4'hC, OP_RSVD = 4'hD, OP_RSV2 = 4'hE, OP_HALT = 4'hF
  } opcode_t;

  state_t     cur, nxt;
  logic [7:0] ir;
  opcode_t    op_q;
  logic [3:0] imm_q;
  logic [3:0] rval_q;
  logic [3:0] regs [4];

  logic [3:0] alu_acc;
  logic       alu_c;
  logic       acc_we;
  logic       c_we;
  logic [4:0] sum_imm, sum_reg, diff_imm;

  assign state = cur;

  // Next-state and per-state control outputs.
  always_comb begin
    nxt       = cur;
    pc_enable = 1'b0;
    halted    = 1'b0;
    case (cur)
      FETCH:   if (run_en) nxt = DECODE;
      DECODE:  nxt = EXECUTE;
      EXECUTE: nxt = (op_q == OP_HALT) ? HALT : ADVANCE;
      ADVANCE: begin
        pc_enable = 1'b1;
        nxt       = FETCH;
      end
      HALT:    halted = 1'b1;
      default: nxt = FETCH;
    endcase
  end

  // State register; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  assign sum_imm  = {1'b0, acc} + {1'b0, imm_q};
  assign sum_reg  = {1'b0, acc} + {1'b0, rval_q};
  // Bit 4 of the 5-bit difference is the unsigned borrow.
  assign diff_imm = {1'b0, acc} - {1'b0, imm_q};

  // ALU result and which of acc/carry the current opcode writes.
  always_comb begin
    alu_acc = acc;
    alu_c   = carry;
    acc_we  = 1'b0;
    c_we    = 1'b0;
    case (op_q)
      OP_LDI:  begin alu_acc = imm_q;          acc_we = 1'b1; end
      OP_ADDI: begin alu_acc = sum_imm[3:0];   alu_c = sum_imm[4];  acc_we = 1'b1; c_we = 1'b1; end
      OP_SUBI: begin alu_acc = diff_imm[3:0];  alu_c = diff_imm[4]; acc_we = 1'b1; c_we = 1'b1; end
      OP_ANDI: begin alu_acc = acc & imm_q;    acc_we = 1'b1; end
      OP_ORI:  begin alu_acc = acc | imm_q;    acc_we = 1'b1; end
      OP_XORI: begin alu_acc = acc ^ imm_q;    acc_we = 1'b1; end
      OP_LDR:  begin alu_acc = rval_q;         acc_we = 1'b1; end
      OP_ADDR: begin alu_acc = sum_reg[3:0];   alu_c = sum_reg[4];  acc_we = 1'b1; c_we = 1'b1; end
      OP_SHL:  begin alu_acc = {acc[2:0], 1'b0}; alu_c = acc[3];    acc_we = 1'b1; c_we = 1'b1; end
      OP_SHR:  begin alu_acc = {1'b0, acc[3:1]}; alu_c = acc[0];    acc_we = 1'b1; c_we = 1'b1; end
      default: ;
    endcase
  end

  // Datapath: IR capture, operand latch, and architectural writes in EXECUTE.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir      <= '0;
      op_q    <= OP_NOP;
      imm_q   <= '0;
      rval_q  <= '0;
      acc     <= '0;
      out_reg <= '0;
      carry   <= 1'b0;
      zero    <= 1'b1;
      for (int unsigned i = 0; i < 4; i++) regs[i] <= REG_INIT;
    end else begin
      case (cur)
        FETCH:  if (run_en) ir <= instruction;
        DECODE: begin
          op_q   <= opcode_t'(ir[7:4]);
          imm_q  <= ir[3:0];
          rval_q <= regs[ir[1:0]];
        end
        EXECUTE: begin
          if (acc_we) begin
            acc  <= alu_acc;
            zero <= (alu_acc == 4'h0);
          end
          if (c_we) carry <= alu_c;
          if (op_q == OP_STR) regs[imm_q[1:0]] <= acc;
          if (op_q == OP_OUT) out_reg <= acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Self-checking bench for cpu_exec_unit: directed scenarios plus random
// instruction streams compared against an arithmetic reference model.
module tb_cpu_exec_unit;

  localparam logic [3:0] INIT = 4'h5;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instruction;
  logic       run_en;
  logic       pc_enable;
  logic [3:0] acc;
  logic [3:0] out_reg;
  logic       carry;
  logic       zero;
  logic       halted;
  logic [2:0] state;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [3:0] m_acc, m_out;
  logic       m_c, m_z, m_h;
  logic [3:0] m_r [4];

  cpu_exec_unit #(.REG_INIT(INIT)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .run_en(run_en),
    .pc_enable(pc_enable), .acc(acc), .out_reg(out_reg), .carry(carry),
    .zero(zero), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model_reset();
    m_acc = '0; m_out = '0; m_c = 1'b0; m_z = 1'b1; m_h = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = INIT;
  endfunction

  function automatic void model_exec(input logic [7:0] ins);
    int a, i, s, sel;
    bit wr;
    a = int'(m_acc); i = int'(ins[3:0]); sel = int'(ins[1:0]); wr = 1'b1;
    case (ins[7:4])
      4'h1: a = i;
      4'h2: begin s = a + i; m_c = (s > 15); a = s % 16; end
      4'h3: begin m_c = (a < i); a = (a - i + 16) % 16; end
      4'h4: a = a & i;
      4'h5: a = a | i;
      4'h6: a = a ^ i;
      4'h7: begin m_r[sel] = m_acc; wr = 1'b0; end
      4'h8: a = int'(m_r[sel]);
      4'h9: begin s = a + int'(m_r[sel]); m_c = (s > 15); a = s % 16; end
      4'hA: begin m_c = (a >= 8); a = (a * 2) % 16; end
      4'hB: begin m_c = ((a % 2) == 1); a = a / 2; end
      4'hC: begin m_out = m_acc; wr = 1'b0; end
      4'hF: begin m_h = 1'b1; wr = 1'b0; end
      default: wr = 1'b0;
    endcase
    if (wr) begin
      m_acc = 4'(a);
      m_z   = (a == 0);
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; run_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Issues one instruction from FETCH and follows it until it returns to
  // FETCH or lands in HALT; inputs are scrambled once it has been latched.
  task automatic run_instr(input logic [7:0] ins, output int cycles,
                           output int pulses, output int bad);
    instruction = ins; run_en = 1'b1;
    cycles = 0; pulses = 0; bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cycles++;
      if (pc_enable) begin
        pulses++;
        if (state != 3'd3) bad++;
      end
      instruction = 8'($urandom);
      run_en      = 1'($urandom);
      if (state == 3'd0 || state == 3'd4) break;
    end
    run_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({state, acc, out_reg, carry, zero, halted, pc_enable} !==
        {3'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got st=%0d acc=%0d out=%0d c=%b z=%b h=%b pe=%b, want st=0 acc=0 out=0 c=0 z=1 h=0 pe=0",
               state, acc, out_reg, carry, zero, halted, pc_enable);
    end
  endtask

  task automatic test_ldi();
    int c, p, b;
    do_reset();
    run_instr(8'h17, c, p, b); model_exec(8'h17);
    n_cmp++;
    if (c !== 4) begin n_fail++; $display("FAIL ldi_cycles: got %0d want 4", c); end
    n_cmp++;
    if (p !== 1 || b !== 0) begin n_fail++; $display("FAIL ldi_pulse: got pulses=%0d outside_adv=%0d want 1/0", p, b); end
    n_cmp++;
    if ({acc, zero, carry} !== {4'd7, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL ldi_result: got acc=%0d z=%b c=%b want 7/0/0", acc, zero, carry);
    end
  endtask

  task automatic test_carry_borrow();
    int c, p, b;
    do_reset();
    run_instr(8'h1F, c, p, b); model_exec(8'h1F);
    run_instr(8'h21, c, p, b); model_exec(8'h21);
    n_cmp++;
    if ({acc, carry, zero} !== {4'd0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL addi_wrap: got acc=%0d c=%b z=%b want 0/1/1", acc, carry, zero);
    end
    run_instr(8'h31, c, p, b); model_exec(8'h31);
    n_cmp++;
    if ({acc, carry, zero} !== {4'd15, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL subi_borrow: got acc=%0d c=%b z=%b want 15/1/0", acc, carry, zero);
    end
  endtask

  task automatic test_store_load();
    int c, p, b;
    logic [7:0] seq [4] = '{8'h19, 8'h72, 8'h10, 8'h92};
    do_reset();
    foreach (seq[i]) begin run_instr(seq[i], c, p, b); model_exec(seq[i]); end
    n_cmp++;
    if ({acc, carry, zero} !== {4'd9, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL str_addr: got acc=%0d c=%b z=%b want 9/0/0", acc, carry, zero);
    end
    run_instr(8'hC0, c, p, b); model_exec(8'hC0);
    n_cmp++;
    if (out_reg !== 4'd9) begin n_fail++; $display("FAIL out_reg: got %0d want 9", out_reg); end
  endtask

  task automatic test_shifts();
    int c, p, b;
    do_reset();
    run_instr(8'h18, c, p, b); run_instr(8'hA0, c, p, b);
    n_cmp++;
    if ({acc, carry, zero} !== {4'd0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL shl: got acc=%0d c=%b z=%b want 0/1/1", acc, carry, zero);
    end
    run_instr(8'h11, c, p, b); run_instr(8'hB0, c, p, b);
    n_cmp++;
    if ({acc, carry, zero} !== {4'd0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL shr: got acc=%0d c=%b z=%b want 0/1/1", acc, carry, zero);
    end
  endtask

  task automatic test_random();
    int c, p, b;
    logic [7:0] ins;
    do_reset();
    for (int n = 0; n < 120; n++) begin
      ins = 8'($urandom);
      if (ins[7:4] == 4'hF) ins[7:4] = 4'h9;
      run_instr(ins, c, p, b);
      model_exec(ins);
      n_cmp++;
      if (c !== 4 || p !== 1 || b !== 0) begin
        n_fail++; $display("FAIL rand_timing[%0d] ins=%h: got cycles=%0d pulses=%0d bad=%0d want 4/1/0", n, ins, c, p, b);
      end
      n_cmp++;
      if ({acc, carry, zero, out_reg, halted} !== {m_acc, m_c, m_z, m_out, m_h}) begin
        n_fail++;
        $display("FAIL rand_state[%0d] ins=%h: got acc=%0d c=%b z=%b out=%0d h=%b want acc=%0d c=%b z=%b out=%0d h=%b",
                 n, ins, acc, carry, zero, out_reg, halted, m_acc, m_c, m_z, m_out, m_h);
      end
    end
  endtask

  task automatic test_run_hold();
    logic [3:0] a0;
    a0 = acc;
    run_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      instruction = 8'($urandom);
      @(negedge clk);
      n_cmp++;
      if (state !== 3'd0 || pc_enable !== 1'b0 || acc !== a0) begin
        n_fail++; $display("FAIL run_hold[%0d]: got st=%0d pe=%b acc=%0d want 0/0/%0d", k, state, pc_enable, acc, a0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int c, p, b, pulses;
    do_reset();
    run_instr(8'h13, c, p, b); model_exec(8'h13);
    instruction = 8'h25; run_en = 1'b1;
    @(negedge clk);
    run_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (state !== 3'd2) begin n_fail++; $display("FAIL mid_in_execute: got st=%0d want 2", state); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    n_cmp++;
    if ({state, acc, carry, zero, pc_enable} !== {3'd0, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL mid_reset: got st=%0d acc=%0d c=%b z=%b pe=%b want 0/0/0/1/0", state, acc, carry, zero, pc_enable);
    end
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (pc_enable) pulses++;
    end
    n_cmp++;
    if (pulses !== 0 || acc !== 4'd0) begin
      n_fail++; $display("FAIL mid_no_pulse: got pulses=%0d acc=%0d want 0/0", pulses, acc);
    end
  endtask

  task automatic test_halt();
    int c, p, b;
    logic [3:0] a0;
    do_reset();
    run_instr(8'h16, c, p, b); model_exec(8'h16);
    a0 = acc;
    run_instr(8'hF0, c, p, b);
    n_cmp++;
    if (halted !== 1'b1 || state !== 3'd4 || p !== 0 || c !== 3) begin
      n_fail++; $display("FAIL halt_enter: got h=%b st=%0d pulses=%0d cycles=%0d want 1/4/0/3", halted, state, p, c);
    end
    for (int k = 0; k < 20; k++) begin
      run_en = 1'b1; instruction = 8'($urandom);
      @(negedge clk);
      n_cmp++;
      if (pc_enable !== 1'b0 || state !== 3'd4 || halted !== 1'b1 || acc !== a0) begin
        n_fail++; $display("FAIL halt_sticky[%0d]: got pe=%b st=%0d h=%b acc=%0d want 0/4/1/%0d", k, pc_enable, state, halted, acc, a0);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; run_en = 1'b0;
    model_reset();
    n_cmp++;
    if (halted !== 1'b0 || state !== 3'd0 || acc !== 4'd0) begin
      n_fail++; $display("FAIL halt_reset: got h=%b st=%0d acc=%0d want 0/0/0", halted, state, acc);
    end
  endtask

  initial begin
    reset = 1'b1; run_en = 1'b0; instruction = '0;
    model_reset();
    test_reset();
    test_ldi();
    test_carry_borrow();
    test_store_load();
    test_shifts();
    test_random();
    test_run_hold();
    test_reset_mid();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
